count_sequencer: RTL and testbench
==================================

Name: count_sequencer

Overview:
- Control FSM and owned count register for the seven-segment up/down seconds counter.
- Consumes one-cycle debounced push-button edge pulses and a one-cycle 1 Hz tick from the existing divider/debounce logic.
- Sequences run/pause, direction and clear, and halts at the count limits.
- Outputs the binary count plus registered BCD digits for the hex-to-seven-segment converters.

Parameters:
- MAX_COUNT, 59, upper count bound; legal range 1..99 so the value fits two BCD digits.
- COUNT_WIDTH, 8, width of count_o; must hold MAX_COUNT.

Ports:
- CLOCK_50_I  input  1  50 MHz system clock; all state updates on its rising edge.
- resetn  input  1  synchronous active-low reset, sampled on the CLOCK_50_I rising edge.
- tick_i  input  1  one-cycle pulse, one per counting period.
- pb_pulse_i  input  4  one-cycle debounced press pulses: [0] run/pause toggle, [1] select up, [2] select down, [3] clear.
- count_o  output  COUNT_WIDTH  current count, binary.
- ones_o  output  4  BCD ones digit of count_o.
- tens_o  output  4  BCD tens digit of count_o.
- state_o  output  2  FSM state: 0=RUN, 1=PAUSE, 2=LIMIT.
- dir_up_o  output  1  1=counting up, 0=counting down.
- limit_o  output  1  one-cycle pulse on entry to LIMIT.

Behaviour:
- Reset (resetn=0 at a clock edge): state=RUN, count_o=0, dir_up_o=1, ones_o=0, tens_o=0, limit_o=0. Reset overrides every other input in that cycle and aborts any operation in progress.
- Per-cycle event priority: clear > run/pause toggle > direction select > tick.
- Clear (pb[3]), accepted in any state:
  - count<=0, dir<=up, state<=PAUSE.
  - All other inputs in that cycle are ignored.
- Toggle (pb[0]):
  - RUN->PAUSE; PAUSE->RUN; LIMIT->RUN.
  - On LIMIT->RUN, counting resumes in the direction already set on LIMIT entry.
  - A tick in the same cycle as a toggle is dropped; count is unchanged.
- Direction select, accepted only in RUN and ignored in PAUSE and LIMIT:
  - pb[1] sets dir<=up; pb[2] sets dir<=down.
  - If pb[1] and pb[2] arrive in the same cycle, down wins.
  - A tick in the same cycle is evaluated with the pre-update direction register; the new direction applies from the next tick.
- Tick in RUN:
  - Up and count<MAX_COUNT: count+1.
  - Up and count==MAX_COUNT: count held; state<=LIMIT; dir<=down; limit_o=1 for that cycle.
  - Down and count>0: count-1.
  - Down and count==0: count held; state<=LIMIT; dir<=up; limit_o=1.
  - If the same cycle also carries a direction select, the LIMIT direction flip overrides it.
  - So each bound value is displayed for one full tick period before the halt.
- Tick in PAUSE or LIMIT: ignored.
- Limits: count_o never leaves 0..MAX_COUNT and never wraps; no arithmetic underflow or overflow is possible.
- Timing:
  - count_o, state_o and dir_up_o update one cycle after the causing event.
  - ones_o = count_o mod 10 and tens_o = count_o / 10 are registered, lagging count_o by exactly one cycle (2 cycles from tick to BCD).
  - limit_o is registered and asserts in the same cycle that state_o first reads LIMIT.
- The block treats pb_pulse_i and tick_i as already single-cycle. A level held high is treated as a fresh event on every cycle; the block does no edge detection.

Test Plan:
- Reset, then 5 ticks -> count_o=5, ones_o=5 and tens_o=0 one cycle after count_o settles; state=RUN; dir_up_o=1.
- Run from 0 with 60 ticks -> count_o reaches 59 on tick 59. Tick 60: count stays 59, state=LIMIT, limit_o pulses once, dir_up_o=0. Tick 61: no change. pb[0], then 3 ticks -> count_o=56, state=RUN.
- At count 10 in RUN: pb[2] then 10 ticks -> count_o=0. Next tick -> LIMIT, dir_up_o=1. pb[1] while in LIMIT -> ignored, dir stays 1.
- At count 20: pb[0] (PAUSE), 4 ticks -> count stays 20. pb[2] in PAUSE -> ignored. pb[0] -> RUN; 1 tick -> 21.
- Simultaneous events at count 30 RUN/up:
  - pb[1]+pb[2]+tick same cycle -> count 31, dir down.
  - Next cycle pb[0]+tick -> PAUSE, count stays 31.
  - pb[3]+pb[0] same cycle -> count 0, dir up, state PAUSE.
- Assert resetn low for one cycle at count 45 mid-RUN -> next edge count_o=0, state RUN, dir up; BCD outputs read 0/0 by the following cycle.

Source files
------------

// File: rtl/count_sequencer.sv
// Run/pause/direction/clear sequencer and count register for the seconds counter.
// The count halts at either bound. The BCD digits are registered one cycle behind the count.
module count_sequencer #(
  parameter int MAX_COUNT   = 59,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   CLOCK_50_I,
  input  logic                   resetn,
  input  logic                   tick_i,
  input  logic [3:0]             pb_pulse_i,
  output logic [COUNT_WIDTH-1:0] count_o,
  output logic [3:0]             ones_o,
  output logic [3:0]             tens_o,
  output logic [1:0]             state_o,
  output logic                   dir_up_o,
  output logic                   limit_o
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_PAUSE = 2'd1,
    S_LIMIT = 2'd2
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] C_MAX  = COUNT_WIDTH'(MAX_COUNT);
  localparam logic [COUNT_WIDTH-1:0] C_ZERO = '0;
  localparam logic [COUNT_WIDTH-1:0] C_ONE  = COUNT_WIDTH'(1);

  // Count is bounded to 0..99, so plain divide/modulo on a 32-bit copy is exact.
  function automatic logic [7:0] to_bcd(input logic [COUNT_WIDTH-1:0] v);
    int unsigned iv;
    iv = 32'(v);
    return {4'(iv / 32'd10), 4'(iv % 32'd10)};
  endfunction

  state_t                 r_state, w_state_nxt;
  logic [COUNT_WIDTH-1:0] r_count, w_count_nxt;
  logic                   r_dir_up, w_dir_nxt;
  logic                   r_limit, w_limit_nxt;
  logic [3:0]             r_ones, r_tens;
  logic [7:0]             w_bcd;

  assign w_bcd = to_bcd(r_count);

  always_ff @(posedge CLOCK_50_I) begin
    if (!resetn) begin
      r_state  <= S_RUN;
      r_count  <= C_ZERO;
      r_dir_up <= 1'b1;
      r_limit  <= 1'b0;
      r_ones   <= 4'd0;
      r_tens   <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_dir_up <= w_dir_nxt;
      r_limit  <= w_limit_nxt;
      r_ones   <= w_bcd[3:0];
      r_tens   <= w_bcd[7:4];
    end
  end

  // Priority: clear > toggle > direction select > tick. A tick uses the pre-update direction.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_dir_nxt   = r_dir_up;
    w_limit_nxt = 1'b0;
    if (pb_pulse_i[3]) begin
      w_count_nxt = C_ZERO;
      w_dir_nxt   = 1'b1;
      w_state_nxt = S_PAUSE;
    end else if (pb_pulse_i[0]) begin
      w_state_nxt = (r_state == S_RUN) ? S_PAUSE : S_RUN;
    end else if (r_state == S_RUN) begin
      if (pb_pulse_i[2]) begin
        w_dir_nxt = 1'b0;
      end else if (pb_pulse_i[1]) begin
        w_dir_nxt = 1'b1;
      end
      if (tick_i) begin
        if (r_dir_up && (r_count < C_MAX)) begin
          w_count_nxt = r_count + C_ONE;
        end else if (!r_dir_up && (r_count > C_ZERO)) begin
          w_count_nxt = r_count - C_ONE;
        end else begin
          // The bound is reached: halt and flip the direction, overriding any select.
          w_state_nxt = S_LIMIT;
          w_dir_nxt   = ~r_dir_up;
          w_limit_nxt = 1'b1;
        end
      end
    end
  end

  assign count_o  = r_count;
  assign ones_o   = r_ones;
  assign tens_o   = r_tens;
  assign state_o  = r_state;
  assign dir_up_o = r_dir_up;
  assign limit_o  = r_limit;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer. A behavioural model is checked on every cycle,
// and hand-computed literal values pin the model at the key points.
module tb_count_sequencer;

  localparam int MAXC = 59;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       tick_i = 1'b0;
  logic [3:0] pb_pulse_i = 4'd0;
  logic [7:0] count_o;
  logic [3:0] ones_o, tens_o;
  logic [1:0] state_o;
  logic       dir_up_o, limit_o;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  count_sequencer #(.MAX_COUNT(MAXC), .COUNT_WIDTH(8)) dut (
    .CLOCK_50_I(clk),
    .resetn(resetn),
    .tick_i(tick_i),
    .pb_pulse_i(pb_pulse_i),
    .count_o(count_o),
    .ones_o(ones_o),
    .tens_o(tens_o),
    .state_o(state_o),
    .dir_up_o(dir_up_o),
    .limit_o(limit_o)
  );

  always #5 clk = ~clk;

  // Model: count value, direction, state (0 run, 1 pause, 2 limit), limit pulse,
  // and the count that the BCD digits must show (the count of the previous cycle).
  typedef struct packed {
    int       cnt;
    bit       up;
    bit [1:0] st;
    bit       lim;
    int       bcd_src;
  } mdl_t;

  mdl_t m = '{cnt: 0, up: 1'b1, st: 2'd0, lim: 1'b0, bcd_src: 0};

  function automatic mdl_t model_next(input mdl_t cur, input bit rn, input bit t, input bit [3:0] pb);
    mdl_t n;
    n = cur;
    n.lim = 1'b0;
    n.bcd_src = cur.cnt;
    if (!rn) begin
      n.cnt = 0; n.up = 1'b1; n.st = 2'd0; n.bcd_src = 0;
    end else if (pb[3]) begin
      n.cnt = 0; n.up = 1'b1; n.st = 2'd1;
    end else if (pb[0]) begin
      n.st = (cur.st == 2'd0) ? 2'd1 : 2'd0;
    end else if (cur.st == 2'd0) begin
      if (t) begin
        if (cur.up && cur.cnt < MAXC) n.cnt = cur.cnt + 1;
        else if (!cur.up && cur.cnt > 0) n.cnt = cur.cnt - 1;
        else begin
          n.st = 2'd2; n.lim = 1'b1; n.up = !cur.up;
        end
      end
      if (!n.lim) begin
        if (pb[2]) n.up = 1'b0;
        else if (pb[1]) n.up = 1'b1;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m <= model_next(m, resetn, tick_i, pb_pulse_i);
    cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input integer act, input integer exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("count_o", integer'(count_o), m.cnt);
      chk("state_o", integer'(state_o), integer'(m.st));
      chk("dir_up_o", integer'(dir_up_o), integer'(m.up));
      chk("limit_o", integer'(limit_o), integer'(m.lim));
      chk("ones_o", integer'(ones_o), m.bcd_src % 10);
      chk("tens_o", integer'(tens_o), m.bcd_src / 10);
    end
  end

  task automatic cycle(input bit rn, input bit t, input logic [3:0] pb);
    resetn = rn;
    tick_i = t;
    pb_pulse_i = pb;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    tick_i = 1'b0;
    pb_pulse_i = 4'd0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, 1'b1, 4'd0);
      cycle(1'b1, 1'b0, 4'd0);
    end
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 4'd0);
    cycle(1'b1, 1'b0, 4'd0);
  endtask

  initial begin
    cycle(1'b0, 1'b0, 4'd0);
    chk_en = 1'b1;
    cycle(1'b0, 1'b0, 4'd0);
    chk("lit_reset_count", integer'(count_o), 0);
    chk("lit_reset_state", integer'(state_o), 0);
    chk("lit_reset_dir", integer'(dir_up_o), 1);
    chk("lit_reset_ones", integer'(ones_o), 0);

    // Five ticks from reset
    cycle(1'b1, 1'b0, 4'd0);
    tick_n(5);
    chk("lit_5_count", integer'(count_o), 5);
    chk("lit_5_ones", integer'(ones_o), 5);
    chk("lit_5_tens", integer'(tens_o), 0);

    // Count to the upper bound and halt
    do_reset();
    tick_n(59);
    chk("lit_59_count", integer'(count_o), 59);
    chk("lit_59_ones", integer'(ones_o), 9);
    chk("lit_59_tens", integer'(tens_o), 5);
    cycle(1'b1, 1'b1, 4'd0);
    chk("lit_lim_state", integer'(state_o), 2);
    chk("lit_lim_pulse", integer'(limit_o), 1);
    chk("lit_lim_dir", integer'(dir_up_o), 0);
    chk("lit_lim_count", integer'(count_o), 59);
    cycle(1'b1, 1'b0, 4'd0);
    chk("lit_lim_pulse_end", integer'(limit_o), 0);
    tick_n(1);
    chk("lit_lim_hold", integer'(count_o), 59);
    cycle(1'b1, 1'b0, 4'b0001);
    tick_n(3);
    chk("lit_resume_count", integer'(count_o), 56);
    chk("lit_resume_state", integer'(state_o), 0);

    // Count down to the lower bound
    do_reset();
    tick_n(10);
    cycle(1'b1, 1'b0, 4'b0100);
    tick_n(10);
    chk("lit_down_zero", integer'(count_o), 0);
    cycle(1'b1, 1'b1, 4'd0);
    chk("lit_low_state", integer'(state_o), 2);
    chk("lit_low_dir", integer'(dir_up_o), 1);
    cycle(1'b1, 1'b0, 4'b0010);
    chk("lit_low_sel_ign", integer'(dir_up_o), 1);

    // Pause and resume
    do_reset();
    tick_n(20);
    cycle(1'b1, 1'b0, 4'b0001);
    tick_n(4);
    chk("lit_pause_count", integer'(count_o), 20);
    cycle(1'b1, 1'b0, 4'b0100);
    chk("lit_pause_dir", integer'(dir_up_o), 1);
    cycle(1'b1, 1'b0, 4'b0001);
    tick_n(1);
    chk("lit_unpause", integer'(count_o), 21);

    // Simultaneous events
    do_reset();
    tick_n(30);
    cycle(1'b1, 1'b1, 4'b0110);
    chk("lit_sim_count", integer'(count_o), 31);
    chk("lit_sim_dir", integer'(dir_up_o), 0);
    cycle(1'b1, 1'b1, 4'b0001);
    chk("lit_sim_pause", integer'(state_o), 1);
    chk("lit_sim_hold", integer'(count_o), 31);
    cycle(1'b1, 1'b0, 4'b1001);
    chk("lit_clr_count", integer'(count_o), 0);
    chk("lit_clr_dir", integer'(dir_up_o), 1);
    chk("lit_clr_state", integer'(state_o), 1);

    // Reset mid-run
    do_reset();
    tick_n(45);
    chk("lit_45_ones", integer'(ones_o), 5);
    chk("lit_45_tens", integer'(tens_o), 4);
    cycle(1'b0, 1'b1, 4'd0);
    chk("lit_rst_count", integer'(count_o), 0);
    chk("lit_rst_state", integer'(state_o), 0);
    chk("lit_rst_dir", integer'(dir_up_o), 1);
    cycle(1'b1, 1'b0, 4'd0);
    chk("lit_rst_ones", integer'(ones_o), 0);
    chk("lit_rst_tens", integer'(tens_o), 0);

    cycle(1'b1, 1'b0, 4'd0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
